// File: rtl/render_pkg.sv
// Shared types and default geometry for the glyph, square and text-layout renderers.
package render_pkg;

    localparam int unsigned DEF_CHAR_W  = 7;
    localparam int unsigned DEF_FONT_W  = 5;
    localparam int unsigned DEF_FONT_H  = 7;
    localparam int unsigned DEF_X_W     = 9;
    localparam int unsigned DEF_Y_W     = 8;
    localparam int unsigned DEF_SCALE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } state_t;

    // Address width for a table of 'value' entries; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/scale_counter.sv
// Modulo-S counter: counts 0..last, flags the final count so callers can cascade.
module scale_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] last,
    output logic         wrap_c
);

    logic [W-1:0] count;

    assign wrap_c = (count == last);

    // Restart on clear, otherwise step and fold back to zero after 'last'.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/glyph_renderer.sv
// Rasterises one scaled glyph from an external font ROM onto a valid/ready pixel stream.
module glyph_renderer
    import render_pkg::*;
#(
    parameter int unsigned CHAR_W  = DEF_CHAR_W,
    parameter int unsigned FONT_W  = DEF_FONT_W,
    parameter int unsigned FONT_H  = DEF_FONT_H,
    parameter int unsigned X_W     = DEF_X_W,
    parameter int unsigned Y_W     = DEF_Y_W,
    parameter int unsigned SCALE_W = DEF_SCALE_W
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [CHAR_W-1:0]         char,
    input  logic [X_W-1:0]            origin_x,
    input  logic [Y_W-1:0]            origin_y,
    input  logic [SCALE_W-1:0]        scale,
    input  logic                      opaque,
    output logic                      rom_en,
    output logic [CHAR_W-1:0]         rom_char,
    output logic [clog2(FONT_H)-1:0]  rom_row,
    input  logic [FONT_W-1:0]         rom_bits,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [X_W-1:0]            out_x,
    output logic [Y_W-1:0]            out_y,
    output logic                      out_fg,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned COL_W = clog2(FONT_W);
    localparam int unsigned ROW_W = clog2(FONT_H);
    localparam int unsigned XP_W  = X_W + 1;
    localparam int unsigned YP_W  = Y_W + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FONT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FONT_H - 1);

    state_t state_q, state_d;

    logic [CHAR_W-1:0]  char_q;
    logic [X_W-1:0]     ox_q;
    logic [SCALE_W-1:0] s_last_q;
    logic               opaque_q;
    logic [FONT_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]   c_q, c_d;
    logic [ROW_W-1:0]   r_q, r_d;
    logic [XP_W-1:0]    x_q, x_d;
    logic [YP_W-1:0]    y_q, y_d;
    logic [FONT_W-1:0]  cand_bits;

    logic accept, step, row_end, sx_wrap, sy_wrap, col_last, row_last, fg_d;
    logic rom_en_d, out_valid_d, out_fg_d, busy_d, done_d;

    assign rom_char = char_q;
    assign rom_row  = r_q;
    assign out_x    = x_q[X_W-1:0];
    assign out_y    = y_q[Y_W-1:0];
    assign col_last = (c_q == COL_LAST);
    assign row_last = (r_q == ROW_LAST);

    // Sub-column advances on every consumed candidate; sub-row at the end of each scan line.
    scale_counter #(.W(SCALE_W)) u_sx (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (accept),
        .advance (step),
        .last    (s_last_q),
        .wrap_c  (sx_wrap)
    );

    scale_counter #(.W(SCALE_W)) u_sy (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (accept),
        .advance (row_end),
        .last    (s_last_q),
        .wrap_c  (sy_wrap)
    );

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, scan position and next registered outputs for the upcoming candidate pixel.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        row_end   = 1'b0;
        row_d     = row_q;
        c_d       = c_q;
        r_d       = r_q;
        x_d       = x_q;
        y_d       = y_q;
        cand_bits = row_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                    c_d     = '0;
                    r_d     = '0;
                    x_d     = {1'b0, origin_x};
                    y_d     = {1'b0, origin_y};
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // Row data arrives now; the first candidate is built straight from it.
                row_d     = rom_bits;
                cand_bits = rom_bits;
                state_d   = EMIT;
            end
            EMIT: begin
                step = !out_valid || out_ready;
                if (step) begin
                    if (sx_wrap && col_last) begin
                        row_end = 1'b1;
                        c_d     = '0;
                        x_d     = {1'b0, ox_q};
                        y_d     = y_q + YP_W'(1);
                        if (sy_wrap) begin
                            if (row_last) begin
                                state_d = DONE;
                            end else begin
                                state_d = FETCH;
                                r_d     = r_q + ROW_W'(1);
                            end
                        end
                    end else begin
                        if (sx_wrap) begin
                            c_d = c_q + COL_W'(1);
                        end
                        x_d = x_q + XP_W'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        fg_d        = cand_bits[COL_LAST - c_d];
        out_fg_d    = (state_d == EMIT) && fg_d;
        out_valid_d = (state_d == EMIT) && (fg_d || opaque_q) && !x_d[X_W] && !y_d[Y_W];
        rom_en_d    = (state_d == FETCH);
        busy_d      = (state_d == FETCH) || (state_d == WAIT) || (state_d == EMIT);
        done_d      = (state_d == DONE);
    end

    // Latched request, scan position and registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            char_q    <= '0;
            ox_q      <= '0;
            s_last_q  <= '0;
            opaque_q  <= 1'b0;
            row_q     <= '0;
            c_q       <= '0;
            r_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rom_en    <= 1'b0;
            out_valid <= 1'b0;
            out_fg    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                char_q   <= char;
                ox_q     <= origin_x;
                s_last_q <= (scale == '0) ? '0 : scale - SCALE_W'(1);
                opaque_q <= opaque;
            end
            row_q     <= row_d;
            c_q       <= c_d;
            r_q       <= r_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rom_en    <= rom_en_d;
            out_valid <= out_valid_d;
            out_fg    <= out_fg_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_glyph_renderer.sv
// Directed bench for glyph_renderer with a behavioural font ROM and pixel-sequence model.
module tb_glyph_renderer;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [6:0] char;
    logic [8:0] origin_x;
    logic [7:0] origin_y;
    logic [3:0] scale;
    logic       opaque;
    logic       rom_en;
    logic [6:0] rom_char;
    logic [2:0] rom_row;
    logic [4:0] rom_bits;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_x;
    logic [7:0] out_y;
    logic       out_fg;
    logic       busy;
    logic       done;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic       fg;
    } px_t;

    typedef struct {
        logic [6:0] ch;
        logic [8:0] ox;
        logic [7:0] oy;
        logic [3:0] sc;
        logic       opq;
        bit         bp;
        bit         poke;
        int         exp_cnt;
        int         fx, fy, lx, ly;
        int         first_cyc;
        int         done_cyc;
    } vec_t;

    glyph_renderer dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .char      (char),
        .origin_x  (origin_x),
        .origin_y  (origin_y),
        .scale     (scale),
        .opaque    (opaque),
        .rom_en    (rom_en),
        .rom_char  (rom_char),
        .rom_row   (rom_row),
        .rom_bits  (rom_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_fg    (out_fg),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // 'A' is a real glyph, space is blank, everything else is an arbitrary pattern.
    function automatic logic [4:0] font_row(input logic [6:0] ch, input logic [2:0] r);
        if (ch == 7'h41) begin
            if (r == 3'd0) return 5'b01110;
            if (r == 3'd3) return 5'b11111;
            return 5'b10001;
        end
        if (ch == 7'h20) return 5'b00000;
        return 5'(ch) ^ 5'(r * 3'd3);
    endfunction

    // Font ROM with one cycle of read latency.
    always @(posedge clock) begin
        if (rom_en) rom_bits <= font_row(rom_char, rom_row);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        px_t  act[$];
        px_t  exp[$];
        px_t  held;
        px_t  p;
        bit   hold;
        int   s, x, y, first_cyc, done_at;
        logic [4:0] bits;
        logic fg;

        s = (v.sc == 4'd0) ? 1 : int'(v.sc);
        for (int r = 0; r < 7; r++)
            for (int sy = 0; sy < s; sy++)
                for (int c = 0; c < 5; c++)
                    for (int sx = 0; sx < s; sx++) begin
                        x    = int'(v.ox) + c * s + sx;
                        y    = int'(v.oy) + r * s + sy;
                        bits = font_row(v.ch, 3'(r));
                        fg   = bits[4 - c];
                        if ((fg || v.opq) && x < 512 && y < 256)
                            exp.push_back('{9'(x), 8'(y), fg});
                    end

        @(negedge clock);
        char = v.ch; origin_x = v.ox; origin_y = v.oy; scale = v.sc; opaque = v.opq;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;

        hold = 1'b0; held = '0; first_cyc = 0; done_at = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clock);
            if (v.poke && n == 20) begin
                start = 1'b1; char = 7'h42; origin_x = 9'd50; opaque = ~v.opq;
            end
            if (n == 21) start = 1'b0;
            if (n == 1) begin
                check($sformatf("v%0d_rom_en", idx), int'(rom_en), 1);
                check($sformatf("v%0d_rom_row", idx), int'(rom_row), 0);
                check($sformatf("v%0d_rom_char", idx), int'(rom_char), int'(v.ch));
                check($sformatf("v%0d_busy", idx), int'(busy), 1);
            end
            if (hold)
                check($sformatf("v%0d_hold_n%0d", idx, n),
                      int'({out_valid, out_x, out_y, out_fg}), int'({1'b1, held}));
            out_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && first_cyc == 0) first_cyc = n;
            p = '{out_x, out_y, out_fg};
            if (out_valid && out_ready) act.push_back(p);
            hold = out_valid && !out_ready;
            held = p;
            if (done) begin
                done_at = n;
                break;
            end
        end
        out_ready = 1'b1;

        check($sformatf("v%0d_done_seen", idx), int'(done_at != 0), 1);
        check($sformatf("v%0d_count", idx), act.size(), v.exp_cnt);
        check($sformatf("v%0d_first_cyc", idx), first_cyc, v.first_cyc);
        if (v.done_cyc != 0) check($sformatf("v%0d_done_cyc", idx), done_at, v.done_cyc);
        if (v.exp_cnt > 0 && act.size() > 0) begin
            check($sformatf("v%0d_first_x", idx), int'(act[0].x), v.fx);
            check($sformatf("v%0d_first_y", idx), int'(act[0].y), v.fy);
            check($sformatf("v%0d_last_x", idx), int'(act[act.size()-1].x), v.lx);
            check($sformatf("v%0d_last_y", idx), int'(act[act.size()-1].y), v.ly);
        end
        check($sformatf("v%0d_seq_len", idx), act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++)
            check($sformatf("v%0d_px%0d", idx, i), int'(act[i]), int'(exp[i]));

        @(negedge clock);
        check($sformatf("v%0d_done_pulse", idx), int'(done), 0);
        check($sformatf("v%0d_idle_busy", idx), int'(busy), 0);
    endtask

    initial begin
        vec_t vecs[9];

        resetn = 1'b0; start = 1'b0; char = '0; origin_x = '0; origin_y = '0;
        scale = '0; opaque = 1'b0; out_ready = 1'b1;

        //         ch     ox       oy      sc     opq   bp poke cnt  fx   fy   lx   ly  fc done
        vecs[0] = '{7'h41, 9'd10,  8'd20,  4'd1, 1'b0, 0, 0,  18,  11,  20,  14,  26, 4, 50};
        vecs[1] = '{7'h41, 9'd0,   8'd0,   4'd2, 1'b1, 0, 0, 140,   0,   0,   9,  13, 3, 155};
        vecs[2] = '{7'h41, 9'd510, 8'd250, 4'd1, 1'b1, 0, 0,  12, 510, 250, 511, 255, 3, 50};
        vecs[3] = '{7'h41, 9'd10,  8'd20,  4'd0, 1'b0, 0, 0,  18,  11,  20,  14,  26, 4, 50};
        vecs[4] = '{7'h20, 9'd100, 8'd100, 4'd3, 1'b0, 0, 0,   0,   0,   0,   0,   0, 0, 330};
        vecs[5] = '{7'h41, 9'd0,   8'd0,   4'd3, 1'b0, 0, 0, 162,   3,   0,  14,  20, 6, 330};
        vecs[6] = '{7'h41, 9'd505, 8'd250, 4'd2, 1'b0, 0, 0,  18, 507, 250, 506, 255, 5, 155};
        vecs[7] = '{7'h41, 9'd0,   8'd0,   4'd2, 1'b1, 1, 0, 140,   0,   0,   9,  13, 3, 0};
        vecs[8] = '{7'h41, 9'd10,  8'd20,  4'd1, 1'b0, 0, 1,  18,  11,  20,  14,  26, 4, 50};

        repeat (2) @(negedge clock);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rom_en", int'(rom_en), 0);
        check("rst_out_x", int'(out_x), 0);
        check("rst_out_y", int'(out_y), 0);
        check("rst_out_fg", int'(out_fg), 0);
        resetn = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset in the middle of an opaque glyph, then render again from scratch.
        @(negedge clock);
        char = 7'h41; origin_x = '0; origin_y = '0; scale = 4'd1; opaque = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        check("mid_pre_valid", int'(out_valid), 1);
        check("mid_pre_busy", int'(busy), 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_rom_en", int'(rom_en), 0);
        @(negedge clock);
        resetn = 1'b1;
        run_vec(9, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Parametrised successor of the fixed-font character renderer.
- Rasterises one glyph of configurable font size at a runtime integer scale, offset from a screen origin.
- Emits one pixel coordinate per accepted transfer on a valid/ready stream toward the framebuffer writer.
- Fetches glyph rows from an external font ROM (1-cycle latency) and supports transparent and opaque background modes.

Parameters:
- CHAR_W, 7, glyph code width (ASCII).
- FONT_W, 5, glyph columns.
- FONT_H, 7, glyph rows.
- X_W, 9, x coordinate width.
- Y_W, 8, y coordinate width.
- SCALE_W, 4, scale factor width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- char  in  CHAR_W  glyph code, latched on accept.
- origin_x  in  X_W  top-left x, latched on accept.
- origin_y  in  Y_W  top-left y, latched on accept.
- scale  in  SCALE_W  pixel magnification, latched; 0 treated as 1.
- opaque  in  1  1 = emit background pixels too, latched.
- rom_en  out  1  font ROM read strobe.
- rom_char  out  CHAR_W  ROM glyph address.
- rom_row  out  clog2(FONT_H)  ROM row address.
- rom_bits  in  FONT_W  row data, valid the cycle after rom_en; bit FONT_W-1 = leftmost column.
- out_valid  out  1  pixel valid.
- out_ready  in  1  consumer accepts pixel.
- out_x  out  X_W  pixel x.
- out_y  out  Y_W  pixel y.
- out_fg  out  1  1 = foreground, 0 = background.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse after the last pixel is handled.

Behaviour:
- Reset (async, any state): state IDLE; all counters 0; rom_en, out_valid, out_x, out_y, out_fg, busy, done = 0.
- FSM states and transitions:
  - IDLE: start=1 latches all inputs, sets busy, goes to FETCH.
  - FETCH: rom_en=1 with rom_char and the current row, then WAIT.
  - WAIT: captures rom_bits into a row register, then EMIT.
  - EMIT: walks the row; see scan order below.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Scan order, innermost first: sub-column sx, column c, sub-row sy, row r.
  - Pixel coordinates: x = origin_x + c*S + sx; y = origin_y + r*S + sy, where S = max(scale, 1).
- Each row is fetched once and reused for all S sub-rows. After the last sub-row, go to FETCH for r+1, or DONE if r = FONT_H-1.
- Fixed latency: start accepted at cycle 0, rom_en at cycle 1, first candidate pixel at cycle 3.
- Emit rules:
  - Foreground pixels are always emitted.
  - Background pixels are emitted only when opaque=1 (out_fg=0).
  - A skipped pixel takes one EMIT cycle with out_valid=0.
- Stream rules:
  - Once out_valid=1, out_x, out_y and out_fg hold stable until out_valid & out_ready.
  - Counters advance only on transfer or skip.
  - Throughput: one pixel per cycle with ready held high.
- Clipping: coordinates are computed at X_W+1 / Y_W+1 bits. Any pixel whose sum overflows X_W or Y_W is suppressed like a skipped pixel; there is no wrap-around.
- start while busy=1 is ignored; latched inputs do not change mid-glyph.
- done rises the cycle after the final transfer or skip. A new start is accepted in the cycle after done.
- Blank glyph in transparent mode: no out_valid at all. Still takes FONT_H*(2 + FONT_W*S*S) EMIT/fetch cycles, then done.
- Counter widths: c is clog2(FONT_W) bits and wraps at FONT_W-1. sx and sy are SCALE_W bits and wrap at S-1.

Decomposition:
- Package render_pkg holds:
  - FSM state enum (IDLE, FETCH, WAIT, EMIT, DONE).
  - Default font and coordinate width constants shared with the square renderer and text layout.
  - clog2 helper.
- Natural sub-module: scale_counter, a parametrised modulo-S counter with advance and wrap outputs. It is instantiated for sx and sy.
- The column and row counters stay inline.

Test Plan:
- Transparent, scale 1: char 'A' at (10,20) with row 0 = 01110 -> exactly 3 pixels (11,20), (12,20), (13,20) first; done after 35 candidate slots; no background pixels.
- Opaque, scale 2: glyph at (0,0) -> 5*7*4 = 140 transfers. Last pixel is (9,13). out_fg matches ROM bits per 2x2 block.
- Backpressure: toggle out_ready randomly -> out_x, out_y, out_fg stable while valid & !ready; pixel sequence identical to the ready=1 run.
- Clipping: origin (510,250), scale 1, opaque -> only pixels with x ≤ 511 and y ≤ 255 emitted (2 columns × 6 rows = 12); done still pulses.
- scale=0 behaves exactly as scale=1. start pulsed mid-glyph with new char is ignored; the output sequence is unchanged.
- resetn asserted during EMIT -> out_valid, busy and done drop immediately. After release, a new start renders from row 0 with cycle-3 first-pixel latency.
